// File: rtl/mag_sq_to_mag_pkg.sv
// Shared definitions for the squared-magnitude to magnitude converter.
//   MAG_SQ_W : width of the incoming squared magnitude
//   MAG_W    : width of the linear magnitude result
//   REM_W    : width of the partial remainder of the digit-by-digit root
//   state_t  : controller states IDLE / CALC / DONE
package mag_sq_to_mag_pkg;

  localparam int MAG_SQ_W = 32;
  localparam int MAG_W    = 16;
  localparam int REM_W    = 18;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mag_sq_to_mag_isqrt_step.sv
// One iteration of the restoring digit-by-digit integer square root.
// Purely combinational.
//   i_rem  : current partial remainder
//   i_root : current partial root
//   i_bits : next two radicand bits (MSB pair first)
//   o_rem  : remainder after this iteration
//   o_root : root after this iteration (one more result bit appended)
module isqrt_step
  import mag_sq_to_mag_pkg::*;
(
  input  logic [REM_W-1:0] i_rem,
  input  logic [MAG_W-1:0] i_root,
  input  logic [1:0]       i_bits,
  output logic [REM_W-1:0] o_rem,
  output logic [MAG_W-1:0] o_root
);

  logic [REM_W-1:0] w_rem_sh;
  logic [REM_W-1:0] w_trial;

  // The remainder never exceeds 2*root+1 before the shift, so dropping
  // its two MSBs here loses nothing.
  assign w_rem_sh = {i_rem[REM_W-3:0], i_bits};
  // The root has at most 15 significant bits when a trial is formed,
  // so {root, 01} fits REM_W bits exactly.
  assign w_trial  = {i_root, 2'b01};

  always_comb begin
    o_rem  = w_rem_sh;
    o_root = {i_root[MAG_W-2:0], 1'b0};
    if (w_rem_sh >= w_trial) begin
      o_rem  = w_rem_sh - w_trial;
      o_root = {i_root[MAG_W-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/mag_sq_to_mag.sv
// Iterative integer square root: 32-bit squared magnitude in, 16-bit
// linear magnitude out. One result bit per enabled cycle, one operation
// in flight, ready/valid accept on the input.
//   ROUND        : 0 = floor(sqrt), 1 = round to nearest (saturating)
//   clock        : rising-edge clock
//   reset        : asynchronous active-high reset
//   enable       : clock enable, holds every register when low
//   mag_sq       : unsigned squared magnitude
//   mag_sq_valid : input qualifier
//   in_ready     : high only while idle
//   mag          : magnitude result, held until the next result
//   mag_valid    : result strobe
module mag_sq_to_mag
  import mag_sq_to_mag_pkg::*;
#(
  parameter int ROUND = 0
)(
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic [MAG_SQ_W-1:0] mag_sq,
  input  logic                mag_sq_valid,
  output logic                in_ready,
  output logic [MAG_W-1:0]    mag,
  output logic                mag_valid
);

  state_t              r_state;
  logic [MAG_SQ_W-1:0] r_rad;
  logic [REM_W-1:0]    r_rem;
  logic [MAG_W-1:0]    r_root;
  logic [3:0]          r_cnt;
  logic [MAG_W-1:0]    r_mag;
  logic                r_mag_valid;
  logic                r_in_ready;

  logic [REM_W-1:0]    w_rem_nxt;
  logic [MAG_W-1:0]    w_root_nxt;

  // Round to nearest: sqrt(n) >= root + 0.5 exactly when the leftover
  // n - root^2 exceeds root. The all-ones root would wrap, so it saturates.
  function automatic logic [MAG_W-1:0] f_final(input logic [MAG_W-1:0] root,
                                               input logic [REM_W-1:0] rem);
    if (ROUND == 0)
      return root;
    if (root == {MAG_W{1'b1}})
      return root;
    if (rem > {{(REM_W-MAG_W){1'b0}}, root})
      return root + 1'b1;
    return root;
  endfunction

  isqrt_step u_step (
    .i_rem  (r_rem),
    .i_root (r_root),
    .i_bits (r_rad[MAG_SQ_W-1:MAG_SQ_W-2]),
    .o_rem  (w_rem_nxt),
    .o_root (w_root_nxt)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_rad       <= '0;
      r_rem       <= '0;
      r_root      <= '0;
      r_cnt       <= '0;
      r_mag       <= '0;
      r_mag_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else if (enable) begin
      // The strobe lasts one enabled edge; only DONE raises it again.
      r_mag_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (mag_sq_valid) begin
            r_rad      <= mag_sq;
            r_rem      <= '0;
            r_root     <= '0;
            r_cnt      <= 4'd15;
            r_in_ready <= 1'b0;
            r_state    <= CALC;
          end
        end
        CALC: begin
          r_rem  <= w_rem_nxt;
          r_root <= w_root_nxt;
          r_rad  <= {r_rad[MAG_SQ_W-3:0], 2'b00};
          if (r_cnt == 4'd0)
            r_state <= DONE;
          else
            r_cnt <= r_cnt - 4'd1;
        end
        DONE: begin
          r_mag       <= f_final(r_root, r_rem);
          r_mag_valid <= 1'b1;
          r_in_ready  <= 1'b1;
          r_state     <= IDLE;
        end
        default: begin
          r_in_ready <= 1'b1;
          r_state    <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign mag       = r_mag;
  assign mag_valid = r_mag_valid;

endmodule

// File: tb/tb_mag_sq_to_mag.sv
// Self-checking bench for mag_sq_to_mag: one truncating and one rounding
// instance share the same stimulus and are compared against a plain
// arithmetic square-root reference.
module tb_mag_sq_to_mag;

  logic        clock;
  logic        reset;
  logic        enable;
  logic [31:0] mag_sq;
  logic        mag_sq_valid;
  logic        t_ready, r_ready;
  logic [15:0] t_mag, r_mag;
  logic        t_vld, r_vld;

  int checks   = 0;
  int failures = 0;

  mag_sq_to_mag #(.ROUND(0)) u_trunc (
    .clock(clock), .reset(reset), .enable(enable), .mag_sq(mag_sq),
    .mag_sq_valid(mag_sq_valid), .in_ready(t_ready), .mag(t_mag), .mag_valid(t_vld)
  );

  mag_sq_to_mag #(.ROUND(1)) u_round (
    .clock(clock), .reset(reset), .enable(enable), .mag_sq(mag_sq),
    .mag_sq_valid(mag_sq_valid), .in_ready(r_ready), .mag(r_mag), .mag_valid(r_vld)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: floor or round-to-nearest square root, saturated to 16 bits.
  function automatic longint ref_sqrt(input longint n, input bit rnd);
    longint r;
    r = longint'($sqrt(real'(n)));
    while (r * r > n) r--;
    while ((r + 1) * (r + 1) <= n) r++;
    if (rnd && (n - r * r > r)) r++;
    if (r > 65535) r = 65535;
    return r;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present one input, wait for acceptance, then count edges to the result.
  // Optional enable stall of stall_len edges starting after edge stall_at.
  task automatic run_one(input logic [31:0] v, input int stall_at, input int stall_len,
                         output int lat, output logic [15:0] m0, output logic [15:0] m1);
    int guard = 0;
    while (!t_ready && guard < 50) begin tick(); guard++; end
    mag_sq       = v;
    mag_sq_valid = 1'b1;
    tick();
    mag_sq_valid = 1'b0;
    lat = 0;
    do begin
      tick();
      lat++;
      if (stall_len > 0 && lat == stall_at) enable = 1'b0;
      if (stall_len > 0 && lat == stall_at + stall_len) enable = 1'b1;
    end while (!t_vld && lat < 60);
    m0 = t_mag;
    m1 = r_mag;
    check("rnd_vld_align", r_vld, 1);
    check("ready_with_vld", t_ready, 1);
  endtask

  task automatic directed(input string tag, input logic [31:0] v,
                          input longint e0, input longint e1);
    int lat;
    logic [15:0] m0, m1;
    run_one(v, 0, 0, lat, m0, m1);
    check({tag, "_lat"}, lat, 17);
    check({tag, "_trunc"}, m0, e0);
    check({tag, "_round"}, m1, e1);
  endtask

  initial begin
    int lat, gap;
    bit seen;
    logic [15:0] m0, m1;
    logic [31:0] v;

    reset        = 1'b1;
    enable       = 1'b1;
    mag_sq       = '0;
    mag_sq_valid = 1'b0;
    tick(); tick();
    check("reset_ready", t_ready, 1);
    check("reset_mag", t_mag, 0);
    check("reset_vld", t_vld, 0);
    reset = 1'b0;
    tick();

    // Basic values and rounding boundaries
    directed("zero",  32'd0,          0,     0);
    directed("one",   32'd1,          1,     1);
    directed("half",  32'h4000_0000,  32768, 32768);
    directed("n30",   32'd30,         5,     5);
    directed("n31",   32'd31,         5,     6);
    directed("allf",  32'hFFFF_FFFF,  65535, 65535);
    tick();
    check("vld_one_cycle", t_vld, 0);

    // Busy drop: valid held high, second value only taken once ready again
    mag_sq       = 32'd100;
    mag_sq_valid = 1'b1;
    tick();
    mag_sq = 32'd400;
    lat = 0;
    do begin tick(); lat++; end while (!t_vld && lat < 60);
    check("busy_first_lat", lat, 17);
    check("busy_first_val", t_mag, 10);
    gap = 0;
    do begin tick(); gap++; end while (!t_vld && gap < 60);
    mag_sq_valid = 1'b0;
    check("busy_gap", gap, 18);
    check("busy_second_val", t_mag, 20);
    tick();

    // Enable stall of 5 edges mid-CALC
    run_one(32'd12345678, 3, 5, lat, m0, m1);
    check("stall_lat", lat, 22);
    check("stall_trunc", m0, ref_sqrt(12345678, 0));
    check("stall_round", m1, ref_sqrt(12345678, 1));
    check("stall_vld_hold", enable, 1);

    // Asynchronous reset at iteration 8 aborts the operation
    mag_sq       = 32'd99999;
    mag_sq_valid = 1'b1;
    tick();
    mag_sq_valid = 1'b0;
    repeat (8) tick();
    #2 reset = 1'b1;
    #1;
    check("abort_ready", t_ready, 1);
    check("abort_mag", t_mag, 0);
    check("abort_vld", t_vld, 0);
    @(negedge clock);
    reset = 1'b0;
    seen = 1'b0;
    repeat (20) begin tick(); if (t_vld) seen = 1'b1; end
    check("abort_no_vld", seen, 0);
    directed("after_abort", 32'd144, 12, 12);

    // Random inputs, back to back at maximum throughput
    for (int i = 0; i < 1500; i++) begin
      v = $urandom >> $urandom_range(0, 31);
      if (i % 4 == 0) v = $urandom;
      run_one(v, 0, 0, lat, m0, m1);
      check("rand_lat", lat, 17);
      check("rand_trunc", m0, ref_sqrt(longint'(v), 0));
      check("rand_round", m1, ref_sqrt(longint'(v), 1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
